prio_arbiter: RTL
=================

# prio_arbiter

Registered N-channel request arbiter: the parametrised, clocked successor to the combinational 4:2 priority encoder in the MSI library. Samples a request vector, issues one registered one-hot grant plus its binary index and a valid flag, and holds the grant until the owner signals completion. Selectable fixed-priority or round-robin mode. Sits in front of shared resources (bus, mux select, demux route) that many channels contend for.

## Interface
- N, 8, number of request channels (2..32)
- IW, $clog2(N), index width (derived; do not override)
- TMO, 16, grant timeout in cycles (used only with ARB_TIMEOUT_EN)

- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- REQ  in  N  per-channel request, level
- DONE  in  1  current owner finished; sampled only while E=1
- MODE  in  1  0 = fixed priority, 1 = round-robin
- GNT  out  N  one-hot grant, registered
- IDX  out  IW  binary index of granted channel, registered
- E  out  1  grant valid (encoder "any" flag, registered)
- TMO_ERR  out  1  one-cycle pulse on forced release by timeout

## Operation
- States: IDLE, GRANT. Reset → IDLE.
- IDLE: if REQ≠0 at an edge, pick winner w; load GNT=1<<w, IDX=w, E=1; → GRANT. If REQ=0, stay; outputs 0.
- Fixed priority (MODE=0): highest set index wins (REQ[N-1] top).
- Round-robin (MODE=1): search ascending from PTR, wrapping at N-1→0; first set bit wins. Wrap is mod N, valid for non-power-of-two N.
- PTR: reset 0; on every release of channel i, PTR ← (i+1) mod N, in both modes.
- GRANT, release conditions at an edge: DONE=1, or REQ[IDX]=0 (abandon), or timeout. On release: GNT=0, E=0, IDX retains last value; → IDLE.
- DONE and REQ[IDX] drop in the same cycle: treated as DONE; single release.
- REQ changes on non-owner channels during GRANT: ignored until the next IDLE.
- MODE sampled only in IDLE; a change during GRANT applies to the next arbitration.
- DONE with E=0: ignored.

## Timing
- Reset values: GNT=0, IDX=0, E=0, TMO_ERR=0, PTR=0, state IDLE. RST mid-grant clears all outputs asynchronously.
- Request-to-grant latency: REQ valid before edge k → GNT/E high after edge k.
- Release: DONE high before edge m → E low after edge m.
- Mandatory one-cycle IDLE bubble between consecutive grants: earliest re-grant at edge m+1.
- GNT, IDX and E change only together, on the same edge.

## Configuration
- ARB_TIMEOUT_EN defined: a counter clears on grant and increments each GRANT cycle. If the count reaches TMO without a release, the grant is force-released on that edge, PTR advances, and TMO_ERR=1 for exactly one cycle.
- Undefined: no counter; a grant is held indefinitely; TMO_ERR tied 0; TMO ignored.

## Structure
- msi_pkg: state encodings (IDLE=0, GRANT=1), MODE encodings (MODE_FIXED=0, MODE_RR=1), and a clog2 helper function.
- Sub-module rr_pick: combinational picker with inputs req[N], start[IW], mode. Outputs are winner index and any-flag. Round-robin uses a double-width masked search. Top level holds the FSM, PTR, output registers and timeout counter.

## Test plan (N=4, TMO=4)
- Reset with REQ=4'b1111 → all outputs 0 during RST; after release, first edge gives GNT=4'b1000, IDX=3, E=1 (MODE=0).
- MODE=0, REQ=4'b0110, DONE after 2 grant cycles → GNT=4'b0100, IDX=2; next grant GNT=4'b0100 again after a 1-cycle E=0 bubble.
- MODE=1, REQ=4'b1111 held, DONE every grant cycle → IDX sequence 0,1,2,3,0 with E toggling 1,0,1,0.
- MODE=1, owner IDX=2 drops REQ[2] without DONE → E=0 next edge; PTR=3; with REQ=4'b0011, next grant IDX=0 (wrap).
- RST asserted mid-GRANT → GNT=0, E=0, IDX=0 immediately; post-reset RR grant starts from PTR=0.
- ARB_TIMEOUT_EN, REQ=4'b0001, DONE never asserted → forced release after 4 GRANT cycles; TMO_ERR high exactly 1 cycle; regrant IDX=0 one cycle later.

Source files
------------

// File: rtl/prio_arbiter_pkg.sv
// Shared encodings and helpers for the registered priority / round-robin arbiter.
package msi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  // Ceiling log2 with a floor of 1 so a 2-channel arbiter still gets a 1-bit index.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int k = 1; k < 31; k++) begin
      if ((1 << r) < n) r = k + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/prio_arbiter_rr_pick.sv
// Combinational winner picker: highest-index-wins in fixed mode, first set bit
// at or above start (wrapping mod N) in round-robin mode.
module rr_pick
  import msi_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  input  logic          mode,
  output logic [IW-1:0] win,
  output logic          any
);

  logic [N-1:0]   low_mask;
  logic [2*N-1:0] masked;
  logic           found;

  // Lower copy is masked below start, upper copy is whole, so the lowest set bit
  // of the doubled vector is the wrapped round-robin winner.
  assign low_mask = (N'(1) << start) - N'(1);
  assign masked   = {req, req & ~low_mask};
  assign any      = |req;

  always_comb begin
    win   = '0;
    found = 1'b0;
    if (mode == MODE_RR) begin
      for (int i = 0; i < 2 * N; i++) begin
        if (!found && masked[i]) begin
          found = 1'b1;
          win   = (i >= N) ? IW'(i - N) : IW'(i);
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) win = IW'(i);
      end
    end
  end

endmodule

// File: rtl/prio_arbiter.sv
// Registered N-channel arbiter holding a one-hot grant until DONE or abandon.
// Optional forced release after TMO grant cycles when ARB_TIMEOUT_EN is defined.
module prio_arbiter
  import msi_pkg::*;
#(
  parameter int N   = 8,
  parameter int IW  = clog2(N),
  parameter int TMO = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [N-1:0]  REQ,
  input  logic          DONE,
  input  logic          MODE,
  output logic [N-1:0]  GNT,
  output logic [IW-1:0] IDX,
  output logic          E,
  output logic          TMO_ERR
);

  if (N < 2 || N > 32) begin : g_bad_n
    $error("prio_arbiter: N must be within 2..32");
  end
  if (TMO < 1) begin : g_bad_tmo
    $error("prio_arbiter: TMO must be at least 1");
  end

  state_e        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] win;
  logic          any;
  logic          user_rel;
  logic          tmo_hit;
  logic [IW-1:0] ptr_next;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req   (REQ),
    .start (ptr),
    .mode  (MODE),
    .win   (win),
    .any   (any)
  );

  // DONE wins over abandon; both are a single ordinary release.
  assign user_rel = DONE || !REQ[IDX];
  assign ptr_next = (IDX == IW'(N - 1)) ? '0 : IDX + 1'b1;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = clog2(TMO + 1);
  logic [CW-1:0] cnt;

  // Counter is zero on the grant edge, so TMO-1 here means TMO grant cycles elapsed.
  assign tmo_hit = (cnt == CW'(TMO - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt     <= '0;
      TMO_ERR <= 1'b0;
    end else begin
      TMO_ERR <= 1'b0;
      if (state == IDLE) begin
        cnt <= '0;
      end else if (user_rel || tmo_hit) begin
        cnt     <= '0;
        TMO_ERR <= !user_rel && tmo_hit;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign TMO_ERR = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      ptr   <= '0;
      GNT   <= '0;
      IDX   <= '0;
      E     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            GNT   <= N'(1) << win;
            IDX   <= win;
            E     <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (user_rel || tmo_hit) begin
            GNT   <= '0;
            E     <= 1'b0;
            ptr   <= ptr_next;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
